// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter feeding one shared ALU through a
//                registered issue stage and a valid/ready result stage.
//                Optional grant locking is compiled in with ALU_ARB_LOCK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    input  logic [4*NREQ-1:0]    req_sh_off,
    input  logic [4*NREQ-1:0]    req_tt,
    input  logic [5*NREQ-1:0]    req_op,
    input  logic [4*NREQ-1:0]    req_dst,

    output logic                 alu_en,
    output logic [15:0]          alu_a,
    output logic [15:0]          alu_b,
    output logic [3:0]           alu_sh_off,
    output logic [3:0]           alu_tt,
    output logic [4:0]           alu_op,
    output logic [3:0]           alu_dst,
    input  logic [15:0]          alu_out,
    input  logic                 alu_carry,
    input  logic                 alu_ovf,
    input  logic [3:0]           alu_o_dst,

    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [15:0]          res_data,
    output logic                 res_carry,
    output logic                 res_ovf,
    output logic [3:0]           res_dst,
    output logic [IDW-1:0]       res_id
);

    localparam logic [IDW-1:0] c_LAST_RST = IDW'(NREQ - 1);

    // Issue stage registers
    logic              r_iss_v_q,   w_iss_v_d;
    logic [15:0]       r_iss_a_q,   w_iss_a_d;
    logic [15:0]       r_iss_b_q,   w_iss_b_d;
    logic [3:0]        r_iss_sh_q,  w_iss_sh_d;
    logic [3:0]        r_iss_tt_q,  w_iss_tt_d;
    logic [4:0]        r_iss_op_q,  w_iss_op_d;
    logic [3:0]        r_iss_dst_q, w_iss_dst_d;
    logic [IDW-1:0]    r_iss_id_q,  w_iss_id_d;

    // Result stage registers
    logic              r_res_v_q,     w_res_v_d;
    logic [15:0]       r_res_data_q,  w_res_data_d;
    logic              r_res_carry_q, w_res_carry_d;
    logic              r_res_ovf_q,   w_res_ovf_d;
    logic [3:0]        r_res_dst_q,   w_res_dst_d;
    logic [IDW-1:0]    r_res_id_q,    w_res_id_d;

    logic [IDW-1:0]    r_last_q,    w_last_d;

    logic              w_res_adv;
    logic              w_acc_ok;
    logic              w_accept;
    logic [NREQ-1:0]   w_elig;
    logic              w_gnt_found;
    logic [IDW-1:0]    w_gnt_idx;
    int                w_cand;
    logic [NREQ-1:0]   w_shift;

    logic [15:0]       w_sel_a;
    logic [15:0]       w_sel_b;
    logic [3:0]        w_sel_sh;
    logic [3:0]        w_sel_tt;
    logic [4:0]        w_sel_op;
    logic [3:0]        w_sel_dst;

    assign w_res_adv = !r_res_v_q || res_ready;
    assign w_acc_ok  = !r_iss_v_q || w_res_adv;

`ifdef ALU_ARB_LOCK_EN
    logic              r_locked_q, w_locked_d;
    logic [IDW-1:0]    r_owner_q,  w_owner_d;
    logic              w_sel_lock;

    // While locked, only the owner is eligible even if it is idle.
    always_comb begin
        w_elig = req_valid;
        if (r_locked_q) begin
            w_elig = req_valid & (NREQ'(1) << r_owner_q);
        end
    end

    always_comb begin
        w_sel_lock = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_sel_lock = req_lock[i];
            end
        end
    end

    // Non-owners are never accepted while locked, so the accepted lock bit
    // alone decides whether the lock is held.
    always_comb begin
        w_locked_d = r_locked_q;
        w_owner_d  = r_owner_q;
        if (w_accept) begin
            w_locked_d = w_sel_lock;
            w_owner_d  = w_gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_locked_q <= 1'b0;
            r_owner_q  <= '0;
        end else begin
            r_locked_q <= w_locked_d;
            r_owner_q  <= w_owner_d;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = ^req_lock;

    always_comb begin
        w_elig = req_valid;
    end
`endif

    // Round-robin search starting one past the last accepted requester.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = r_last_q;
        w_cand      = 0;
        w_shift     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand  = (int'(r_last_q) + k) % NREQ;
            w_shift = w_elig >> w_cand;
            if (!w_gnt_found && w_shift[0]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IDW'(w_cand);
            end
        end
    end

    assign w_accept = w_gnt_found && w_acc_ok && !rst;

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready = NREQ'(1) << w_gnt_idx;
        end
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sh  = '0;
        w_sel_tt  = '0;
        w_sel_op  = '0;
        w_sel_dst = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == IDW'(i)) begin
                w_sel_a   = req_a[16*i +: 16];
                w_sel_b   = req_b[16*i +: 16];
                w_sel_sh  = req_sh_off[4*i +: 4];
                w_sel_tt  = req_tt[4*i +: 4];
                w_sel_op  = req_op[5*i +: 5];
                w_sel_dst = req_dst[4*i +: 4];
            end
        end
    end

    always_comb begin
        w_iss_v_d     = r_iss_v_q;
        w_iss_a_d     = r_iss_a_q;
        w_iss_b_d     = r_iss_b_q;
        w_iss_sh_d    = r_iss_sh_q;
        w_iss_tt_d    = r_iss_tt_q;
        w_iss_op_d    = r_iss_op_q;
        w_iss_dst_d   = r_iss_dst_q;
        w_iss_id_d    = r_iss_id_q;
        w_res_v_d     = r_res_v_q;
        w_res_data_d  = r_res_data_q;
        w_res_carry_d = r_res_carry_q;
        w_res_ovf_d   = r_res_ovf_q;
        w_res_dst_d   = r_res_dst_q;
        w_res_id_d    = r_res_id_q;
        w_last_d      = r_last_q;

        // The ALU bus is only sampled while the issue stage drives alu_en.
        if (w_res_adv) begin
            w_res_v_d = r_iss_v_q;
            if (r_iss_v_q) begin
                w_res_data_d  = alu_out;
                w_res_carry_d = alu_carry;
                w_res_ovf_d   = alu_ovf;
                w_res_dst_d   = alu_o_dst;
                w_res_id_d    = r_iss_id_q;
            end
        end

        if (w_accept) begin
            w_iss_v_d   = 1'b1;
            w_iss_a_d   = w_sel_a;
            w_iss_b_d   = w_sel_b;
            w_iss_sh_d  = w_sel_sh;
            w_iss_tt_d  = w_sel_tt;
            w_iss_op_d  = w_sel_op;
            w_iss_dst_d = w_sel_dst;
            w_iss_id_d  = w_gnt_idx;
            w_last_d    = w_gnt_idx;
        end else if (w_res_adv) begin
            w_iss_v_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_v_q     <= 1'b0;
            r_iss_a_q     <= '0;
            r_iss_b_q     <= '0;
            r_iss_sh_q    <= '0;
            r_iss_tt_q    <= '0;
            r_iss_op_q    <= '0;
            r_iss_dst_q   <= '0;
            r_iss_id_q    <= '0;
            r_res_v_q     <= 1'b0;
            r_res_data_q  <= '0;
            r_res_carry_q <= 1'b0;
            r_res_ovf_q   <= 1'b0;
            r_res_dst_q   <= '0;
            r_res_id_q    <= '0;
            r_last_q      <= c_LAST_RST;
        end else begin
            r_iss_v_q     <= w_iss_v_d;
            r_iss_a_q     <= w_iss_a_d;
            r_iss_b_q     <= w_iss_b_d;
            r_iss_sh_q    <= w_iss_sh_d;
            r_iss_tt_q    <= w_iss_tt_d;
            r_iss_op_q    <= w_iss_op_d;
            r_iss_dst_q   <= w_iss_dst_d;
            r_iss_id_q    <= w_iss_id_d;
            r_res_v_q     <= w_res_v_d;
            r_res_data_q  <= w_res_data_d;
            r_res_carry_q <= w_res_carry_d;
            r_res_ovf_q   <= w_res_ovf_d;
            r_res_dst_q   <= w_res_dst_d;
            r_res_id_q    <= w_res_id_d;
            r_last_q      <= w_last_d;
        end
    end

    assign alu_en     = r_iss_v_q;
    assign alu_a      = r_iss_a_q;
    assign alu_b      = r_iss_b_q;
    assign alu_sh_off = r_iss_sh_q;
    assign alu_tt     = r_iss_tt_q;
    assign alu_op     = r_iss_op_q;
    assign alu_dst    = r_iss_dst_q;

    assign res_valid  = r_res_v_q;
    assign res_data   = r_res_data_q;
    assign res_carry  = r_res_carry_q;
    assign res_ovf    = r_res_ovf_q;
    assign res_dst    = r_res_dst_q;
    assign res_id     = r_res_id_q;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and two-stage issue pipeline sharing one `alu` instance among `NREQ` requesters (sequencers, address generators, decode units). Each requester presents a complete ALU micro-op with a valid/ready handshake. The block registers the winning op into an issue stage that drives the ALU ports, then captures the ALU result, flags and tags into a result register with its own valid/ready handshake. It sits between the requesters and the `alu` instance; nothing else drives the ALU inputs.

## Interface
Parameters:
- `NREQ`, 2: number of requesters. Legal range 2..4.
- `IDW`, 2: requester-id width. Must be at least $clog2(NREQ).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: per-requester op valid.
- `req_ready` out NREQ: per-requester accept. At most one bit is high.
- `req_lock` in NREQ: hold the grant after this op. Used only with the lock feature; see Configuration.
- `req_a`, `req_b` in 16*NREQ: operands, packed, requester i at [16i+15:16i].
- `req_sh_off` in 4*NREQ, `req_tt` in 4*NREQ, `req_op` in 5*NREQ, `req_dst` in 4*NREQ: ALU controls, packed the same way.
- `alu_en` out 1: drives ALU `en`.
- `alu_a`, `alu_b` out 16; `alu_sh_off` out 4; `alu_tt` out 4; `alu_op` out 5; `alu_dst` out 4: registered ALU inputs.
- `alu_out` in 16; `alu_carry` in 1; `alu_ovf` in 1; `alu_o_dst` in 4: ALU outputs.
- `res_valid` out 1: result register holds data.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 16; `res_carry` out 1; `res_ovf` out 1; `res_dst` out 4; `res_id` out IDW: captured result, flags, destination and originating requester.

## Operation
- **Result stage** (`res_v`): advances (`res_adv`) when `!res_v || res_ready`.
  - On `res_adv`, it loads from the issue stage if `iss_v`; otherwise it clears.
- **Issue stage** (`iss_v`): can accept (`acc_ok`) when `!iss_v || res_adv`.
- **Grant**:
  - Round-robin, searching from `(last+1) mod NREQ` upward. `last` is the index of the last accepted requester; reset value is NREQ-1, so requester 0 wins first.
  - `req_ready[g] = acc_ok && req_valid[g]` for the winner g; all other bits are 0.
  - `req_ready` depends combinationally on `req_valid`. A requester's `req_valid` must never depend on its `req_ready`.
- **Accept** (`req_valid[g] && req_ready[g]`):
  - Load the issue register with requester g's fields and id g.
  - Set `iss_v` and set `last=g`.
- **Issue drain**: when `res_adv && iss_v` and there is no accept, `iss_v` clears.
- `alu_en = iss_v`. The ALU output is sampled only while `alu_en=1`, so the high-Z bus is never captured.
- The result stage captures `alu_out`, `alu_carry`, `alu_ovf` and `alu_o_dst`, plus id from the issue register.
- A stalled result (`res_valid && !res_ready`) holds every `res_*` output stable.
- The block performs no width arithmetic. All fields pass through unmodified.

## Timing
- Reset, while `rst` is high and asynchronously:
  - `iss_v=0`, `res_v=0`, `last=NREQ-1`, lock state cleared.
  - All `alu_*` and `res_*` outputs are 0.
  - `req_ready` is forced to 0.
- Latency: op accepted at edge T. `alu_en=1` during cycle T..T+1, and `res_valid=1` from edge T+1.
- Throughput: one op per cycle while `res_ready=1`.
- Backpressure:
  - `res_ready=0` with both stages full gives `req_ready=0` for all requesters.
  - Raising `res_ready` allows a new accept in the same cycle.
- Simultaneous result pop and accept in one cycle: the result stage takes the issue op, and the issue stage takes the new op. No bubble is inserted.
- Reset asserted mid-operation discards both stages; no result is produced.

## Configuration
- `ALU_ARB_LOCK_EN` defined (lock feature compiled in):
  - An accept with `req_lock[g]=1` sets `locked=1` and `owner=g`.
  - While `locked`, only `owner` can be granted. Other requesters see `req_ready=0` even if the owner is idle.
  - An accept from the owner with `req_lock=0` clears `locked`. This supports multi-word carry chains.
- Not defined: `req_lock` is ignored, and there is no lock state.

## Test plan
- Reset, then req 0 presents a=0x1234, b=0x0001, op=add (bit0=1), dst=3 with `res_ready=1` -> `alu_en` high cycle after accept; `res_valid` next edge with `res_data=0x1235`, `res_dst=3`, `res_id=0`.
- All requesters are valid every cycle for 8 cycles with `res_ready=1` -> grants follow 0,1,0,1... for NREQ=2 and 0,1,2,3,0... for NREQ=4; the result stream matches that order with no bubbles.
- `res_ready=0` for 5 cycles with req 0 streaming -> exactly two ops are accepted; `res_*` holds the first result stable; after `res_ready=1`, results emerge in order with none lost or duplicated.
- A logic op with `truth_table=4'b0110` (XOR), a=0x00FF, b=0x0F0F, sh_off=0, op=5'b00000 -> `res_data=0x0FF0`, `res_id` equals the issuing requester.
- `rst` pulsed mid-stream with both stages full -> `res_valid`, `alu_en` and `req_ready` drop immediately; after release, the next grant goes to requester 0.
- With `ALU_ARB_LOCK_EN`: req 1 is accepted with lock=1 while req 0 and req 1 are both valid -> req 1 is granted 3 consecutive times until its lock=0 op, then req 0 is granted. Without the macro -> grants alternate 1,0,1.
